// File: rtl/pulse_stretch_mc.sv
`timescale 1ns/1ps
// Multi-channel trigger pulse stretcher: each channel turns a trigger into a
// fixed-width pulse followed by a holdoff window. Optional input synchroniser.
module pulse_stretch_mc #(
    parameter int unsigned CH_NUM      = 3,
    parameter int unsigned PULSE_W     = 50,
    parameter int unsigned HOLD_W      = 205,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = 0,
    parameter int unsigned RETRIG      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH_NUM-1:0] i_trig,
    output logic [CH_NUM-1:0] o_pulse,
    output logic [CH_NUM-1:0] o_busy,
    output logic [CH_NUM-1:0] o_overrun
);

    localparam int unsigned MAX_W   = (PULSE_W > HOLD_W) ? PULSE_W : HOLD_W;
    localparam int unsigned CNT_W   = $clog2(MAX_W + 1);
    localparam int unsigned HOLD_M1 = (HOLD_W > 0) ? (HOLD_W - 1) : 0;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_M1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [CH_NUM-1:0] trig_s;
    logic [CH_NUM-1:0] trig_d;
    logic [CH_NUM-1:0] qual;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [CH_NUM-1:0] sync_q [SYNC_STAGES];

            // Synchroniser chain bringing i_trig into the i_clk domain
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    sync_q[0] <= i_trig;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign trig_s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign trig_s = i_trig;
        end
    endgenerate

    // Delayed copy for edge detection; cleared by reset so a held trigger reads as an edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trig_d <= '0;
        end else begin
            trig_d <= trig_s;
        end
    end

    assign qual = (EDGE_MODE != 0) ? (trig_s & ~trig_d) : trig_s;

    generate
        for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             pulse_q;
            logic             busy_q;
            logic             ovr_q;
            logic             ovr_d;
            logic             served_q;
            logic             served_d;
            logic             new_req;

            // In level mode a trigger that is still held from the episode it started
            // is the same request, not a fresh one to be reported as dropped.
            assign new_req = (EDGE_MODE != 0) ? qual[g] : (qual[g] & ~served_q);

            // Channel state, counter and registered outputs
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    pulse_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    ovr_q    <= 1'b0;
                    served_q <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    pulse_q  <= (state_d == ST_PULSE);
                    busy_q   <= (state_d != ST_IDLE);
                    ovr_q    <= ovr_d;
                    served_q <= served_d;
                end
            end

            // Next-state, counter and overrun decode
            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                ovr_d    = 1'b0;
                served_d = trig_s[g] & (served_q | ((state_q == ST_IDLE) & qual[g]));
                case (state_q)
                    ST_IDLE: begin
                        if (qual[g]) begin
                            state_d = ST_PULSE;
                            cnt_d   = '0;
                        end
                    end
                    ST_PULSE: begin
                        if (qual[g] && (RETRIG != 0)) begin
                            cnt_d = '0;
                        end else begin
                            ovr_d = new_req;
                            if (cnt_q == PULSE_LAST) begin
                                cnt_d   = '0;
                                state_d = (HOLD_W > 0) ? ST_HOLD : ST_IDLE;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        ovr_d = new_req;
                        if (cnt_q == HOLD_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign o_pulse[g]   = pulse_q;
            assign o_busy[g]    = busy_q;
            assign o_overrun[g] = ovr_q;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_stretch_mc.sv
`timescale 1ns/1ps
// Bench for pulse_stretch_mc: four parameterisations, table of trigger patterns
// with expected waveform metrics, plus hand-written reset sequences.
module tb_pulse_stretch_mc;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0][2:0] trig;
    logic [3:0][2:0] pulse;
    logic [3:0][2:0] busy;
    logic [3:0][2:0] ovr;

    int n_chk = 0;
    int n_err = 0;

    localparam int D_DEF  = 0;
    localparam int D_EDGE = 1;
    localparam int D_RTG  = 2;
    localparam int D_FAST = 3;

    always #5 clk = ~clk;

    pulse_stretch_mc #(.CH_NUM(3), .PULSE_W(50), .HOLD_W(205), .SYNC_STAGES(2),
                       .EDGE_MODE(0), .RETRIG(0)) u_def (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig[0]),
        .o_pulse(pulse[0]), .o_busy(busy[0]), .o_overrun(ovr[0]));

    pulse_stretch_mc #(.CH_NUM(3), .PULSE_W(50), .HOLD_W(205), .SYNC_STAGES(2),
                       .EDGE_MODE(1), .RETRIG(0)) u_edge (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig[1]),
        .o_pulse(pulse[1]), .o_busy(busy[1]), .o_overrun(ovr[1]));

    pulse_stretch_mc #(.CH_NUM(3), .PULSE_W(10), .HOLD_W(20), .SYNC_STAGES(2),
                       .EDGE_MODE(1), .RETRIG(1)) u_rtg (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig[2]),
        .o_pulse(pulse[2]), .o_busy(busy[2]), .o_overrun(ovr[2]));

    pulse_stretch_mc #(.CH_NUM(3), .PULSE_W(1), .HOLD_W(0), .SYNC_STAGES(0),
                       .EDGE_MODE(0), .RETRIG(0)) u_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig[3]),
        .o_pulse(pulse[3]), .o_busy(busy[3]), .o_overrun(ovr[3]));

    // One stimulus record: trigger shape (cycle indices from the first drive) and
    // expected metrics of the lowest masked channel over the observation window.
    typedef struct {
        int         dut;
        logic [2:0] mask;
        int         len1;
        int         off2;
        int         len2;
        int         window;
        int         lat;
        int         high;
        int         rises;
        int         busy;
        int         ovr;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vt [NVEC];
    vec_t exp_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit active(input vec_t v, input int c);
        return (c < v.len1) || ((v.len2 > 0) && (c >= v.off2) && (c < v.off2 + v.len2));
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        int   prim;
        int   lat;
        int   high;
        int   rises;
        int   bsy;
        int   ov;
        int   ov_run;
        int   misalign;
        int   leak;
        logic p;
        logic prev_p;
        logic prev_o;
        string nm;
        v        = vt[idx];
        prim     = v.mask[0] ? 0 : (v.mask[1] ? 1 : 2);
        lat      = -1;
        high     = 0;
        rises    = 0;
        bsy      = 0;
        ov       = 0;
        ov_run   = 0;
        misalign = 0;
        leak     = 0;
        prev_p   = 1'b0;
        prev_o   = 1'b0;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        trig[v.dut] = active(v, 0) ? v.mask : 3'b000;
        for (int k = 1; k <= v.window; k++) begin
            @(posedge clk);
            #1;
            trig[v.dut] = active(v, k) ? v.mask : 3'b000;
            @(negedge clk);
            p = pulse[v.dut][prim];
            if (p && (lat < 0)) lat = k - 1;
            if (p) high++;
            if (p && !prev_p) rises++;
            if (busy[v.dut][prim]) bsy++;
            if (ovr[v.dut][prim]) ov++;
            if (ovr[v.dut][prim] && prev_o) ov_run++;
            prev_p = p;
            prev_o = ovr[v.dut][prim];
            for (int ch = 0; ch < 3; ch++) begin
                if (v.mask[ch]) begin
                    if ({pulse[v.dut][ch], busy[v.dut][ch], ovr[v.dut][ch]} !==
                        {pulse[v.dut][prim], busy[v.dut][prim], ovr[v.dut][prim]})
                        misalign++;
                end else if (pulse[v.dut][ch] || busy[v.dut][ch] || ovr[v.dut][ch]) begin
                    leak++;
                end
            end
        end
        trig[v.dut] = 3'b000;
        e = exp_q.pop_front();
        nm = $sformatf("vec%0d", idx);
        chk({nm, ".latency"},  lat,      e.lat);
        chk({nm, ".high"},     high,     e.high);
        chk({nm, ".rises"},    rises,    e.rises);
        chk({nm, ".busy"},     bsy,      e.busy);
        chk({nm, ".overrun"},  ov,       e.ovr);
        chk({nm, ".ovr_len"},  ov_run,   0);
        chk({nm, ".align"},    misalign, 0);
        chk({nm, ".isolate"},  leak,     0);
    endtask

    initial begin
        int   found;
        int   any_p;
        int   any_b;
        int   e_rise;
        int   e_busy;
        int   e_ovr;
        logic prev;

        // dut  mask   len1 off2 len2 win   lat high rises busy ovr
        vt[0] = '{D_DEF,  3'b001,    1,   0, 0,  300, 2,  50, 1,  255, 0};
        vt[1] = '{D_DEF,  3'b111,    1,   0, 0,  300, 2,  50, 1,  255, 0};
        vt[2] = '{D_DEF,  3'b010, 1000,   0, 0, 1100, 2, 200, 4, 1020, 0};
        vt[3] = '{D_EDGE, 3'b001,    1,  20, 1,  300, 2,  50, 1,  255, 1};
        vt[4] = '{D_EDGE, 3'b100,    1, 100, 1,  300, 2,  50, 1,  255, 1};
        vt[5] = '{D_EDGE, 3'b010,    5,   0, 0,  300, 2,  50, 1,  255, 0};
        vt[6] = '{D_RTG,  3'b001,    1,   5, 1,   80, 2,  15, 1,   35, 0};
        vt[7] = '{D_RTG,  3'b010,    1,  20, 1,   80, 2,  10, 1,   30, 1};
        vt[8] = '{D_FAST, 3'b111,    8,   0, 0,   20, 0,   4, 4,    4, 0};
        vt[9] = '{D_FAST, 3'b001,    1,   0, 0,   10, 0,   1, 1,    1, 0};

        rst_n = 1'b0;
        trig  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset.pulse%0d", d), int'(pulse[d]), 0);
            chk($sformatf("reset.busy%0d", d),  int'(busy[d]),  0);
            chk($sformatf("reset.ovr%0d", d),   int'(ovr[d]),   0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Reset asserted in the middle of a pulse abandons it with nothing after release;
        // an edge-mode trigger held through reset fires exactly once afterwards.
        @(posedge clk);
        #1;
        trig[D_DEF] = 3'b001;
        @(posedge clk);
        #1;
        trig[D_DEF] = 3'b000;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pulse[D_DEF][0]) begin
                found = 1;
                break;
            end
        end
        chk("rst.pulse_started", found, 1);
        repeat (24) @(negedge clk);
        chk("rst.pulse_cycle25", int'(pulse[D_DEF][0]), 1);
        #2;
        rst_n = 1'b0;
        trig[D_EDGE] = 3'b001;
        #1;
        chk("rst.async_pulse", int'(pulse[D_DEF]), 0);
        chk("rst.async_busy",  int'(busy[D_DEF]),  0);
        chk("rst.async_ovr",   int'(ovr[D_DEF]),   0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        any_p  = 0;
        any_b  = 0;
        e_rise = 0;
        e_busy = 0;
        e_ovr  = 0;
        prev   = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pulse[D_DEF] != 3'b000) any_p++;
            if (busy[D_DEF] != 3'b000) any_b++;
            if (pulse[D_EDGE][0] && !prev) e_rise++;
            if (busy[D_EDGE][0]) e_busy++;
            if (ovr[D_EDGE][0]) e_ovr++;
            prev = pulse[D_EDGE][0];
        end
        trig[D_EDGE] = 3'b000;
        chk("rst.no_residual_pulse", any_p, 0);
        chk("rst.no_residual_busy",  any_b, 0);
        chk("rst.held_edge_rises",   e_rise, 1);
        chk("rst.held_edge_busy",    e_busy, 255);
        chk("rst.held_edge_ovr",     e_ovr,  0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
